// File: rtl/mem_stage.sv
// Memory-access stage: LD/ST become a req/ack transaction on the data-memory port,
// all other ops retire through a one-cycle register; holds the CMP flags.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [4:0]  opcode,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  input  logic [1:0]  flags_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        valid_out,
  output logic        wb_en,
  output logic [4:0]  rd_out,
  output logic [31:0] wb_data,
  output logic [1:0]  flags_out,
  output logic        err,
  output logic        o_dbg_state
);

  localparam logic [4:0] OP_ST  = 5'b11100;
  localparam logic [4:0] OP_LD  = 5'b11101;
  localparam logic [4:0] OP_CMP = 5'b10010;
  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  // Handshake: an op is transferred on a rising edge where valid_in & ready_out;
  // ready_out is high exactly while the FSM sits in IDLE.
  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_valid_out;
  logic        r_wb_en;
  logic [4:0]  r_rd_out;
  logic [31:0] r_wb_data;
  logic [1:0]  r_flags;
  logic        r_err;

  logic        w_accept;
  logic        w_is_mem;
  logic        w_in_access;
  logic        w_ack_done;
  logic        w_timeout;

  function automatic logic f_wb_en(input logic [4:0] op);
    return ((op >= 5'd2)  && (op <= 5'd8))  ||
           ((op >= 5'd10) && (op <= 5'd14)) ||
           (op == 5'd16) || (op == 5'd17) || (op == 5'd30);
  endfunction

  assign w_accept    = valid_in && (r_state == S_IDLE);
  assign w_is_mem    = (opcode == OP_LD) || (opcode == OP_ST);
  assign w_in_access = (r_state == S_ACCESS);
  assign w_ack_done  = w_in_access && mem_ack;
  // An ack arriving in the last allowed cycle wins over the timeout.
  assign w_timeout   = w_in_access && !mem_ack && (r_cnt == LP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mem) begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (w_ack_done || w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 8'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_valid_out <= 1'b0;
      r_wb_en     <= 1'b0;
      r_rd_out    <= 5'd0;
      r_wb_data   <= 32'd0;
      r_flags     <= 2'd0;
      r_err       <= 1'b0;
    end else begin
      r_valid_out <= 1'b0;
      r_wb_en     <= 1'b0;
      r_err       <= 1'b0;
      if (w_accept) begin
        r_rd_out <= rd_in;
        if (w_is_mem) begin
          r_mem_addr  <= alu_out;
          r_mem_wdata <= store_data;
          r_mem_we    <= (opcode == OP_ST);
          r_mem_req   <= 1'b1;
          r_cnt       <= 8'd0;
        end else begin
          r_valid_out <= 1'b1;
          r_wb_en     <= f_wb_en(opcode);
          r_wb_data   <= alu_out;
          if (opcode == OP_CMP) begin
            r_flags <= flags_in;
          end
        end
      end else if (w_ack_done) begin
        r_mem_req   <= 1'b0;
        r_valid_out <= 1'b1;
        r_wb_en     <= !r_mem_we;
        if (!r_mem_we) begin
          r_wb_data <= mem_rdata;
        end
      end else if (w_timeout) begin
        // Abort: retire without a register write and flag the error.
        r_mem_req   <= 1'b0;
        r_valid_out <= 1'b1;
        r_err       <= 1'b1;
      end else if (w_in_access) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign ready_out   = (r_state == S_IDLE);
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign valid_out   = r_valid_out;
  assign wb_en       = r_wb_en;
  assign rd_out      = r_rd_out;
  assign wb_data     = r_wb_data;
  assign flags_out   = r_flags;
  assign err         = r_err;
  assign o_dbg_state = r_state;

  a_req_matches_state: assert property (@(posedge clk) disable iff (!rst_n)
    r_mem_req == (r_state == S_ACCESS));

  a_err_is_retire: assert property (@(posedge clk) disable iff (!rst_n)
    r_err |-> (r_valid_out && !r_wb_en));

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage (TIMEOUT=4): directed scenarios plus a retire scoreboard
// that pops one expected {wb_en, rd, wb_data, err} record per valid_out pulse.
module tb_mem_stage;

  localparam logic [4:0] OP_ST  = 5'b11100;
  localparam logic [4:0] OP_LD  = 5'b11101;
  localparam logic [4:0] OP_CMP = 5'b10010;
  localparam logic [4:0] OP_ADD = 5'b00010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [4:0]  opcode = 5'd0;
  logic [31:0] alu_out = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic [1:0]  flags_in = 2'd0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;
  logic        valid_out;
  logic        wb_en;
  logic [4:0]  rd_out;
  logic [31:0] wb_data;
  logic [1:0]  flags_out;
  logic        err;
  logic        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // {wb_en, rd[4:0], wb_data[31:0], err}
  logic [38:0] exp_q[$];
  logic [31:0] m_wb_data = 32'd0;
  logic [1:0]  m_flags   = 2'd0;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out),
    .opcode(opcode), .alu_out(alu_out), .store_data(store_data), .rd_in(rd_in),
    .flags_in(flags_in), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .valid_out(valid_out), .wb_en(wb_en), .rd_out(rd_out), .wb_data(wb_data),
    .flags_out(flags_out), .err(err), .o_dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic exp_wb_en(input logic [4:0] op);
    case (op)
      5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
      5'd10, 5'd11, 5'd12, 5'd13, 5'd14,
      5'd16, 5'd17, 5'd30: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // driver tasks
  task automatic drive_op(input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] sd, input logic [4:0] rd,
                          input logic [1:0] fl);
    valid_in   = 1'b1;
    opcode     = op;
    alu_out    = a;
    store_data = sd;
    rd_in      = rd;
    flags_in   = fl;
  endtask

  task automatic push_exp(input logic we, input logic [4:0] rd,
                          input logic [31:0] d, input logic e);
    exp_q.push_back({we, rd, d, e});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && valid_out) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_retire: got wb_en=%0b rd=%0d data=%h err=%0b, none expected",
                 wb_en, rd_out, wb_data, err);
      end else begin
        logic [38:0] e;
        e = exp_q.pop_front();
        if ({wb_en, rd_out, wb_data, err} !== e) begin
          n_fail++;
          $display("FAIL sb_retire: got wb_en=%0b rd=%0d data=%h err=%0b, expected wb_en=%0b rd=%0d data=%h err=%0b",
                   wb_en, rd_out, wb_data, err, e[38], e[37:33], e[32:1], e[0]);
        end
      end
    end
    if (rst_n && err && !valid_out) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_err_without_retire: err=1 valid_out=0");
    end
  end

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({mem_req, mem_we, valid_out, wb_en, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got req/we/vo/wb/err=%b, expected 00000",
               {mem_req, mem_we, valid_out, wb_en, err});
    end
    n_tests++;
    if ({mem_addr, mem_wdata, wb_data} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h wdata=%h wb_data=%h, expected 0", mem_addr, mem_wdata, wb_data);
    end
    n_tests++;
    if ({rd_out, flags_out} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_rd_flags: got rd=%0d flags=%b, expected 0", rd_out, flags_out);
    end
    n_tests++;
    if (ready_out !== 1'b1 || dbg_state !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got ready=%b state=%b, expected 1/0", ready_out, dbg_state);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pass_through;
    drive_op(OP_ADD, 32'h0000_0005, 32'h0, 5'd3, 2'b11);
    push_exp(1'b1, 5'd3, 32'h5, 1'b0);
    m_wb_data = 32'h5;
    @(negedge clk);
    valid_in = 1'b0;
    n_tests++;
    if ({valid_out, wb_en, rd_out, wb_data} !== {1'b1, 1'b1, 5'd3, 32'h5}) begin
      n_fail++;
      $display("FAIL pass_retire: got vo=%b wb=%b rd=%0d data=%h, expected 1 1 3 5",
               valid_out, wb_en, rd_out, wb_data);
    end
    n_tests++;
    if (flags_out !== m_flags) begin
      n_fail++;
      $display("FAIL pass_flags: got %b, expected %b", flags_out, m_flags);
    end
    @(negedge clk);
    n_tests++;
    if (valid_out !== 1'b0 || wb_en !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_pulse: got vo=%b wb=%b, expected 0 0", valid_out, wb_en);
    end
  endtask

  task automatic test_cmp;
    drive_op(OP_CMP, 32'h7, 32'h0, 5'd4, 2'b10);
    push_exp(1'b0, 5'd4, 32'h7, 1'b0);
    @(negedge clk);
    drive_op(OP_ADD, 32'h9, 32'h0, 5'd5, 2'b01);
    push_exp(1'b1, 5'd5, 32'h9, 1'b0);
    m_flags = 2'b10;
    m_wb_data = 32'h9;
    n_tests++;
    if (valid_out !== 1'b1 || wb_en !== 1'b0) begin
      n_fail++;
      $display("FAIL cmp_wb_en: got vo=%b wb=%b, expected 1 0", valid_out, wb_en);
    end
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    n_tests++;
    if (flags_out !== 2'b10) begin
      n_fail++;
      $display("FAIL cmp_flags: got %b, expected 10", flags_out);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 16; i++) begin
      logic [4:0]  op;
      logic [31:0] a;
      logic [4:0]  rd;
      logic [1:0]  fl;
      op = 5'($urandom_range(0, 31));
      if (op == OP_LD || op == OP_ST) op = OP_CMP;
      a  = $urandom;
      rd = 5'($urandom_range(0, 31));
      fl = 2'($urandom_range(0, 3));
      n_tests++;
      if (ready_out !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready: got %b, expected 1 at op %0d", ready_out, i);
      end
      drive_op(op, a, $urandom, rd, fl);
      push_exp(exp_wb_en(op), rd, a, 1'b0);
      m_wb_data = a;
      if (op == OP_CMP) m_flags = fl;
      @(negedge clk);
    end
    valid_in = 1'b0;
    @(negedge clk);
    n_tests++;
    if (flags_out !== m_flags) begin
      n_fail++;
      $display("FAIL b2b_flags: got %b, expected %b", flags_out, m_flags);
    end
  endtask

  task automatic test_ld_delay;
    drive_op(OP_LD, 32'h100, 32'h0, 5'd7, 2'b00);
    push_exp(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0);
    m_wb_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
      n_tests++;
      if ({mem_req, mem_we, ready_out} !== 3'b100 || mem_addr !== 32'h100) begin
        n_fail++;
        $display("FAIL ld_access: cycle %0d got req=%b we=%b ready=%b addr=%h, expected 1 0 0 100",
                 i, mem_req, mem_we, ready_out, mem_addr);
      end
      if (i == 2) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    n_tests++;
    if ({mem_req, valid_out, wb_en, ready_out} !== 4'b0111 || wb_data !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL ld_retire: got req=%b vo=%b wb=%b ready=%b data=%h, expected 0 1 1 1 deadbeef",
               mem_req, valid_out, wb_en, ready_out, wb_data);
    end
  endtask

  task automatic test_st_ack;
    drive_op(OP_ST, 32'h40, 32'h1234, 5'd2, 2'b00);
    push_exp(1'b0, 5'd2, m_wb_data, 1'b0);
    @(negedge clk);
    valid_in = 1'b0;
    n_tests++;
    if ({mem_req, mem_we} !== 2'b11 || mem_wdata !== 32'h1234 || mem_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL st_access: got req=%b we=%b wdata=%h addr=%h, expected 1 1 1234 40",
               mem_req, mem_we, mem_wdata, mem_addr);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    n_tests++;
    if ({valid_out, wb_en, ready_out} !== 3'b101) begin
      n_fail++;
      $display("FAIL st_retire: got vo=%b wb=%b ready=%b, expected 1 0 1", valid_out, wb_en, ready_out);
    end
    drive_op(OP_ADD, 32'h11, 32'h0, 5'd6, 2'b00);
    push_exp(1'b1, 5'd6, 32'h11, 1'b0);
    m_wb_data = 32'h11;
    @(negedge clk);
    valid_in = 1'b0;
    n_tests++;
    if ({valid_out, wb_en, rd_out} !== {1'b1, 1'b1, 5'd6} || wb_data !== 32'h11) begin
      n_fail++;
      $display("FAIL st_next_add: got vo=%b wb=%b rd=%0d data=%h, expected 1 1 6 11",
               valid_out, wb_en, rd_out, wb_data);
    end
  endtask

  task automatic test_timeout;
    int cnt;
    drive_op(OP_LD, 32'h200, 32'h0, 5'd9, 2'b00);
    push_exp(1'b0, 5'd9, m_wb_data, 1'b1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
      if (!mem_req) break;
      cnt++;
    end
    n_tests++;
    if (cnt != 4) begin
      n_fail++;
      $display("FAIL to_req_cycles: got %0d, expected 4", cnt);
    end
    n_tests++;
    if ({err, valid_out, wb_en, ready_out} !== 4'b1101) begin
      n_fail++;
      $display("FAIL to_pulse: got err=%b vo=%b wb=%b ready=%b, expected 1 1 0 1",
               err, valid_out, wb_en, ready_out);
    end
    @(negedge clk);
    n_tests++;
    if (err !== 1'b0 || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL to_one_cycle: got err=%b vo=%b, expected 0 0", err, valid_out);
    end
    // ack on the final allowed cycle must win over the timeout
    drive_op(OP_LD, 32'h300, 32'h0, 5'd10, 2'b00);
    push_exp(1'b1, 5'd10, 32'hCAFE_0001, 1'b0);
    m_wb_data = 32'hCAFE_0001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
      n_tests++;
      if (mem_req !== 1'b1) begin
        n_fail++;
        $display("FAIL to_ack_req: cycle %0d got req=%b, expected 1", i, mem_req);
      end
      if (i == 3) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_0001;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    n_tests++;
    if ({err, valid_out, wb_en} !== 3'b011 || wb_data !== 32'hCAFE_0001) begin
      n_fail++;
      $display("FAIL to_ack_wins: got err=%b vo=%b wb=%b data=%h, expected 0 1 1 cafe0001",
               err, valid_out, wb_en, wb_data);
    end
    // stray ack while idle
    mem_ack = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mem_ack = 1'b0;
    n_tests++;
    if ({valid_out, mem_req, ready_out} !== 3'b001 || wb_data !== m_wb_data) begin
      n_fail++;
      $display("FAIL idle_ack_ignored: got vo=%b req=%b ready=%b data=%h, expected 0 0 1 %h",
               valid_out, mem_req, ready_out, wb_data, m_wb_data);
    end
  endtask

  task automatic test_async_reset;
    drive_op(OP_LD, 32'h500, 32'h0, 5'd11, 2'b00);
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_in_access: got req=%b, expected 1", mem_req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({mem_req, mem_we, valid_out, wb_en, err, ready_out} !== 6'b000001) begin
      n_fail++;
      $display("FAIL ar_immediate: got req/we/vo/wb/err/ready=%b, expected 000001",
               {mem_req, mem_we, valid_out, wb_en, err, ready_out});
    end
    n_tests++;
    if ({mem_addr, mem_wdata, wb_data, rd_out, flags_out} !== 103'd0) begin
      n_fail++;
      $display("FAIL ar_data: got addr=%h wdata=%h data=%h rd=%0d flags=%b, expected 0",
               mem_addr, mem_wdata, wb_data, rd_out, flags_out);
    end
    m_wb_data = 32'd0;
    m_flags   = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if ({valid_out, err, mem_req, ready_out} !== 4'b0001) begin
        n_fail++;
        $display("FAIL ar_after: cycle %0d got vo=%b err=%b req=%b ready=%b, expected 0 0 0 1",
                 i, valid_out, err, mem_req, ready_out);
      end
    end
    drive_op(OP_ADD, 32'h77, 32'h0, 5'd1, 2'b00);
    push_exp(1'b1, 5'd1, 32'h77, 1'b0);
    m_wb_data = 32'h77;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_cmp();
    test_back_to_back();
    test_ld_delay();
    test_st_ack();
    test_timeout();
    test_async_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d retires outstanding, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
